// File: rtl/nbit_logic_unit_seq.sv
// Registered, opcode-selected N-bit logic unit with valid/ready handshake on both sides.
// Define NBIT_LU_BIST_EN to build in the exhaustive self-test sweep and its signature.
module nbit_logic_unit_seq #(
    parameter  int WIDTH     = 4,
    localparam int BIT_STATE = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_zero,
    input  logic             bist_start,
    output logic             bist_busy,
    output logic             bist_done,
    output logic [WIDTH-1:0] bist_sig
);

    function automatic logic [WIDTH-1:0] lu_eval(
        input logic [2:0]       f_op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        r = a;
        unique case (f_op)
            3'b000: r = ~a;
            3'b001: r = a & b;
            3'b010: r = a | b;
            3'b011: r = ~(a & b);
            3'b100: r = ~(a | b);
            3'b101: r = a ^ b;
            3'b110: r = ~(a ^ b);
            3'b111: r = a;
            default: r = a;
        endcase
        return r;
    endfunction

    logic             fsm_idle;
    logic             accept;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_zero_q, out_zero_d;
    logic [WIDTH-1:0] op_res;

    assign in_ready = fsm_idle && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign op_res   = lu_eval(op, in1, in2);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        out_zero_d  = out_zero_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_d       = op_res;
            out_zero_d  = (op_res == '0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_zero  = out_zero_q;

`ifdef NBIT_LU_BIST_EN
    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_e;

    // Vector counter layout, LSB first: op, in2, in1 (op sweeps innermost).
    localparam int VEC_W = 3 + 2 * $clog2(BIT_STATE);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [WIDTH-1:0] sweep_res;

    assign sweep_res = lu_eval(vec_q[2:0], vec_q[VEC_W-1 -: WIDTH], vec_q[WIDTH+2 -: WIDTH]);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        sig_d   = sig_q;
        unique case (state_q)
            IDLE: begin
                if (bist_start && !out_valid_q) begin
                    state_d = SWEEP;
                    vec_d   = '0;
                    sig_d   = '0;
                end
            end
            SWEEP: begin
                sig_d = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ sweep_res;
                vec_d = vec_q + VEC_W'(1);
                if (&vec_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            sig_q   <= sig_d;
        end
    end

    assign fsm_idle  = (state_q == IDLE);
    assign bist_busy = (state_q == SWEEP);
    assign bist_done = (state_q == DONE);
    assign bist_sig  = sig_q;
`else
    wire unused_ok = &{1'b0, bist_start, (BIT_STATE == 0)};

    assign fsm_idle  = 1'b1;
    assign bist_busy = 1'b0;
    assign bist_done = 1'b0;
    assign bist_sig  = '0;
`endif

endmodule

// File: tb/tb_nbit_logic_unit_seq.sv
// Directed self-checking bench for nbit_logic_unit_seq (WIDTH=4); sweep tests
// are compiled in when NBIT_LU_BIST_EN is defined.
module tb_nbit_logic_unit_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] in1, in2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         out_zero;
    logic         bist_start;
    logic         bist_busy;
    logic         bist_done;
    logic [W-1:0] bist_sig;

    int total = 0;
    int bad   = 0;

    nbit_logic_unit_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .in1        (in1),
        .in2        (in2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .out_zero   (out_zero),
        .bist_start (bist_start),
        .bist_busy  (bist_busy),
        .bist_done  (bist_done),
        .bist_sig   (bist_sig)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] lu_model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        case (f)
            3'd0: return ~a;
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return a ^ b;
            3'd6: return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    function automatic logic [W-1:0] sig_model();
        logic [W-1:0] s;
        s = '0;
        for (int a = 0; a < 2 ** W; a++)
            for (int b = 0; b < 2 ** W; b++)
                for (int f = 0; f < 8; f++)
                    s = {s[W-2:0], s[W-1]} ^ lu_model(f[2:0], a[W-1:0], b[W-1:0]);
        return s;
    endfunction

`ifdef NBIT_LU_BIST_EN
    // Runs one sweep from IDLE and reports what was observed around it.
    task automatic run_sweep(output logic [W-1:0] sig, output int busy_cnt,
                             output int done_cnt, output logic rdy_seen);
        int cyc;
        busy_cnt = 0;
        done_cnt = 0;
        rdy_seen = 1'b0;
        cyc      = 0;
        in_valid   = 1'b0;
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        in_valid = 1'b1; op = 3'd1; in1 = '1; in2 = '1;
        while (bist_busy && cyc < 5000) begin
            busy_cnt++;
            if (in_ready) rdy_seen = 1'b1;
            if (bist_done) done_cnt++;
            step();
            cyc++;
        end
        if (bist_done) done_cnt++;
        if (in_ready) rdy_seen = 1'b1;
        in_valid = 1'b0;
        step();
        if (bist_done) done_cnt++;
        step();
        if (bist_done) done_cnt++;
        sig = bist_sig;
    endtask
`endif

    logic [3:0] exp_t2 [8] = '{4'b0011, 4'b1000, 4'b1110, 4'b0111,
                               4'b0001, 4'b0110, 4'b1001, 4'b1100};

    initial begin
        int v, n_out, dups, cyc;
        logic [W:0]   q[$];
        logic [W:0]   e;
        logic [W-1:0] r;

        rst_n = 1'b0; in_valid = 1'b1; op = 3'd7; in1 = 4'hF; in2 = 4'hF;
        out_ready = 1'b0; bist_start = 1'b0;

        // Reset held two cycles with a pending operand
        step();
        step();
        check("rst_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_zero", out_zero, 0);
        check("rst_busy", bist_busy, 0);
        check("rst_sig", bist_sig, 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        check("rst_ready", in_ready, 1);
        check("rst_valid_post", out_valid, 0);

        // All opcodes on 1100 / 1010, back to back
        out_ready = 1'b1;
        in1 = 4'b1100; in2 = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            op = i[2:0]; in_valid = 1'b1;
            step();
            check($sformatf("op%0d_valid", i), out_valid, 1);
            check($sformatf("op%0d_out", i), out, exp_t2[i]);
            check($sformatf("op%0d_zero", i), out_zero, 0);
        end
        op = 3'd1; in1 = 4'b0011; in2 = 4'b1100;
        step();
        check("and_zero_out", out, 0);
        check("and_zero_flag", out_zero, 1);
        in_valid = 1'b0;
        step();
        check("drain_valid", out_valid, 0);
        check("drain_hold", out, 0);

        // Backpressure
        in_valid = 1'b1; op = 3'd1; in1 = 4'b1111; in2 = 4'b0101; out_ready = 1'b0;
        step();
        check("bp_out", out, 4'b0101);
        op = 3'd2; in1 = 4'b0000; in2 = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", in_ready, 0);
            step();
            check("bp_stable", out, 4'b0101);
            check("bp_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        step();
        check("bp_replace", out, 4'b0011);
        check("bp_replace_valid", out_valid, 1);
        in_valid = 1'b0;
        step();
        check("bp_consume", out_valid, 0);
        check("bp_hold", out, 4'b0011);

        // Exhaustive operand/op sweep through the handshake with random backpressure
        v = 0; n_out = 0; dups = 0; cyc = 0;
        while ((v < 2048 || q.size() != 0) && cyc < 20000) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (v < 2048);
            op  = v[2:0];
            in2 = v[6:3];
            in1 = v[10:7];
            #1;
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) dups++;
                else begin
                    e = q.pop_front();
                    check("exh", {out_zero, out}, e);
                end
            end
            if (in_valid && in_ready) begin
                r = lu_model(op, in1, in2);
                q.push_back({r == '0, r});
                v++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("exh_accepted", v, 2048);
        check("exh_results", n_out, 2048);
        check("exh_dups", dups, 0);
        step();
        check("exh_idle", out_valid, 0);

`ifdef NBIT_LU_BIST_EN
        begin
            logic [W-1:0] s1, s2, s3, ms;
            int           bc, dc;
            logic         rs;
            ms = sig_model();
            run_sweep(s1, bc, dc, rs);
            check("bist_busy_cycles", bc, 2048);
            check("bist_done_pulses", dc, 1);
            check("bist_ready_low", rs, 0);
            check("bist_sig", s1, ms);
            check("bist_no_out", out_valid, 0);
            run_sweep(s2, bc, dc, rs);
            check("bist_rerun_sig", s2, ms);
            check("bist_rerun_busy", bc, 2048);

            // Reset in the middle of a sweep
            bist_start = 1'b1;
            step();
            bist_start = 1'b0;
            for (int i = 0; i < 1000; i++) step();
            check("mid_busy_before", bist_busy, 1);
            rst_n = 1'b0;
            step();
            check("mid_busy", bist_busy, 0);
            check("mid_sig", bist_sig, 0);
            check("mid_done", bist_done, 0);
            check("mid_ready", in_ready, 1);
            rst_n = 1'b1;
            step();
            run_sweep(s3, bc, dc, rs);
            check("mid_fresh_sig", s3, ms);
            check("mid_fresh_busy", bc, 2048);
        end
`else
        bist_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("nobist_busy", bist_busy, 0);
            check("nobist_done", bist_done, 0);
            check("nobist_sig", bist_sig, 0);
            check("nobist_ready", in_ready, 1);
        end
        bist_start = 1'b0;
        in_valid = 1'b1; op = 3'd5; in1 = 4'b0110; in2 = 4'b0101;
        step();
        check("nobist_op_after", out, lu_model(3'd5, 4'b0110, 4'b0101));
        in_valid = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
